// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: Moore FSM driving datapath enables and selects.
// Define MC_CONTROLLER_BNE_EN to add the BNE branch state (op 000101).
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic [2:0] aluop,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       regdst,
    output logic       memtoreg,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        BNE    = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_FUNCT = 3'b011;

`ifdef MC_CONTROLLER_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    state_t state_q, state_d;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYP:      state_d = EXEC;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    OP_BNE:       state_d = BNE_EN ? BNE : FETCH;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            EXEC:   state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset masks the decode so FETCH's irwrite/pcen stay low until reset is released.
    always_comb begin
        aluop    = ALU_ADD;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        pcen     = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        iord     = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    alusrcb = 2'b01;
                    irwrite = 1'b1;
                    pcen    = 1'b1;
                end
                DECODE: alusrcb = 2'b11;
                MEMADR, ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                MEMRD: iord = 1'b1;
                MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                EXEC: begin
                    alusrca = 1'b1;
                    aluop   = ALU_FUNCT;
                end
                ALUWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                ADDIWB: regwrite = 1'b1;
                BEQ, BNE: begin
                    alusrca = 1'b1;
                    aluop   = ALU_SUB;
                    pcsrc   = 2'b01;
                    pcen    = (state_q == BEQ) ? zero : ~zero;
                end
                JUMP: begin
                    pcsrc = 2'b10;
                    pcen  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction state-sequence model plus
// per-state control table, compared against the DUT on every falling clock edge.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic [2:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen, irwrite, memwrite, regwrite, iord, regdst, memtoreg;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    logic        chk_en = 1'b0;
    logic [3:0]  exp_state = 4'd0;
    logic [13:0] ctl_table [0:12];
    logic [13:0] exp_ctl;
    logic        exp_pcen;
    logic [3:0]  seq [0:7];
    int          seq_len;

    // Control word layout: {aluop[2:0], alusrca, alusrcb[1:0], pcsrc[1:0],
    //                       irwrite, memwrite, regwrite, iord, regdst, memtoreg}
    localparam logic [13:0] RST_CTL = 14'b010_0_00_00_000000;

    mc_controller dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .zero     (zero),
        .aluop    (aluop),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .pcsrc    (pcsrc),
        .pcen     (pcen),
        .irwrite  (irwrite),
        .memwrite (memwrite),
        .regwrite (regwrite),
        .iord     (iord),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected state walk of one instruction, FETCH through its last state.
    task automatic build_seq(input logic [5:0] opcode);
        seq[0] = 4'd0;
        seq[1] = 4'd1;
        seq_len = 2;
        case (opcode)
            6'b100011: begin seq[2] = 4'd2; seq[3] = 4'd3; seq[4] = 4'd4; seq_len = 5; end
            6'b101011: begin seq[2] = 4'd2; seq[3] = 4'd5; seq_len = 4; end
            6'b000000: begin seq[2] = 4'd6; seq[3] = 4'd7; seq_len = 4; end
            6'b001000: begin seq[2] = 4'd9; seq[3] = 4'd10; seq_len = 4; end
            6'b000100: begin seq[2] = 4'd8; seq_len = 3; end
            6'b000010: begin seq[2] = 4'd11; seq_len = 3; end
`ifdef MC_CONTROLLER_BNE_EN
            6'b000101: begin seq[2] = 4'd12; seq_len = 3; end
`endif
            default: seq_len = 2;
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (reset) begin
                exp_ctl  = RST_CTL;
                exp_pcen = 1'b0;
            end else begin
                exp_ctl  = ctl_table[exp_state];
                exp_pcen = (exp_state == 4'd0) || (exp_state == 4'd11) ||
                           (exp_state == 4'd8 && zero) || (exp_state == 4'd12 && !zero);
            end
            check_value("state",    int'(state),    reset ? 0 : int'(exp_state));
            check_value("aluop",    int'(aluop),    int'(exp_ctl[13:11]));
            check_value("alusrca",  int'(alusrca),  int'(exp_ctl[10]));
            check_value("alusrcb",  int'(alusrcb),  int'(exp_ctl[9:8]));
            check_value("pcsrc",    int'(pcsrc),    int'(exp_ctl[7:6]));
            check_value("irwrite",  int'(irwrite),  int'(exp_ctl[5]));
            check_value("memwrite", int'(memwrite), int'(exp_ctl[4]));
            check_value("regwrite", int'(regwrite), int'(exp_ctl[3]));
            check_value("iord",     int'(iord),     int'(exp_ctl[2]));
            check_value("regdst",   int'(regdst),   int'(exp_ctl[1]));
            check_value("memtoreg", int'(memtoreg), int'(exp_ctl[0]));
            check_value("pcen",     int'(pcen),     int'(exp_pcen));
        end
    end

    // op is only meaningful in DECODE/MEMADR and zero only in branch states; elsewhere
    // both are scrambled to show they are ignored.
    task automatic apply_stimulus(input logic [5:0] opcode, input logic z,
                                  input int exp_lat, input string name);
        int measured;
        logic [3:0] s;
        build_seq(opcode);
        check_value({name, " model latency"}, seq_len, exp_lat);
        measured = 9;
        for (int i = 0; i < 8; i++) begin
            s = (i < seq_len) ? seq[i] : 4'd0;
            exp_state = s;
            op   = (s == 4'd1 || s == 4'd2) ? opcode : 6'($urandom);
            zero = (s == 4'd8 || s == 4'd12) ? z : 1'($urandom);
            @(posedge clk);
            #1;
            if (state == 4'd0) begin
                measured = i + 1;
                break;
            end
        end
        check_value({name, " latency"}, measured, exp_lat);
        exp_state = 4'd0;
    endtask

    task automatic mid_reset();
        exp_state = 4'd0;
        op = 6'($urandom);
        @(posedge clk); #1;
        exp_state = 4'd1;
        op = 6'b100011;
        @(posedge clk); #1;
        exp_state = 4'd2;
        @(posedge clk); #1;
        exp_state = 4'd3;
        op = 6'($urandom);
        #1;
        check_value("pre-reset MEMRD", int'(state), 3);
        reset = 1'b1;
        exp_state = 4'd0;
        #1;
        check_value("async reset state", int'(state), 0);
        check_value("async reset pcen", int'(pcen), 0);
        check_value("async reset irwrite", int'(irwrite), 0);
        check_value("async reset aluop", int'(aluop), 2);
        @(posedge clk); #1;
        check_value("held reset state", int'(state), 0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        ctl_table[0]  = 14'b010_0_01_00_100000;
        ctl_table[1]  = 14'b010_0_11_00_000000;
        ctl_table[2]  = 14'b010_1_10_00_000000;
        ctl_table[3]  = 14'b010_0_00_00_000100;
        ctl_table[4]  = 14'b010_0_00_00_001001;
        ctl_table[5]  = 14'b010_0_00_00_010100;
        ctl_table[6]  = 14'b011_1_00_00_000000;
        ctl_table[7]  = 14'b010_0_00_00_001010;
        ctl_table[8]  = 14'b110_1_00_01_000000;
        ctl_table[9]  = 14'b010_1_10_00_000000;
        ctl_table[10] = 14'b010_0_00_00_001000;
        ctl_table[11] = 14'b010_0_00_10_000000;
        ctl_table[12] = 14'b110_1_00_01_000000;

        #1 reset = 1'b1;
        #1;
        check_value("reset state", int'(state), 0);
        check_value("reset pcen", int'(pcen), 0);
        check_value("reset irwrite", int'(irwrite), 0);
        check_value("reset aluop", int'(aluop), 2);
        chk_en = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_value("release state", int'(state), 0);
        check_value("release pcen", int'(pcen), 1);
        check_value("release irwrite", int'(irwrite), 1);
        check_value("release alusrcb", int'(alusrcb), 1);

        apply_stimulus(6'b100011, 1'b0, 5, "lw");
        apply_stimulus(6'b101011, 1'b0, 4, "sw");
        apply_stimulus(6'b000000, 1'b0, 4, "rtype");
        apply_stimulus(6'b001000, 1'b0, 4, "addi");
        apply_stimulus(6'b000100, 1'b1, 3, "beq taken");
        apply_stimulus(6'b000100, 1'b0, 3, "beq not taken");
        apply_stimulus(6'b000010, 1'b0, 3, "jump");
        apply_stimulus(6'b111111, 1'b0, 2, "unknown op");
`ifdef MC_CONTROLLER_BNE_EN
        apply_stimulus(6'b000101, 1'b0, 3, "bne taken");
        apply_stimulus(6'b000101, 1'b1, 3, "bne not taken");
`else
        apply_stimulus(6'b000101, 1'b0, 2, "bne disabled");
        apply_stimulus(6'b000101, 1'b1, 2, "bne disabled z1");
`endif
        mid_reset();
        apply_stimulus(6'b100011, 1'b1, 5, "lw after reset");
        apply_stimulus(6'b000000, 1'b1, 4, "rtype after reset");

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
